par_serial_tx: RTL and testbench

- Downstream stage of the word memory register: consumes its WORD_SIZE-bit output words and serialises them one bit per clock.
- Accepts words over a valid/ready handshake.
- Has a one-entry holding buffer, so back-to-back words stream with no idle bit between frames.
- Produces serial data, a bit-valid strobe, a frame-start marker and a running count of transmitted words.

---
 rtl/par_serial_pkg.sv | 25 ++
 rtl/par_serial_hold.sv | 27 ++
 rtl/par_serial_tx.sv | 123 ++++++++++++
 tb/tb_par_serial_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/par_serial_pkg.sv
// rtl/par_serial_pkg.sv - shared constants and helpers for the parallel-to-serial transmitter
package par_serial_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT
   } state_t;

   // Ceiling log2, never below 1 so a counter always has at least one bit
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/par_serial_hold.sv
// rtl/par_serial_hold.sv - one-entry word buffer queued behind the active shifter
module par_serial_hold #(
   parameter int WORD_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 clear,
   input  logic [WORD_SIZE-1:0] load_data,
   output logic [WORD_SIZE-1:0] hold_data,
   output logic                 hold_valid
);

   // Capture a word on load, release it on clear; load wins if both ever coincide
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_data  <= '0;
         hold_valid <= 1'b0;
      end else if (load) begin
         hold_data  <= load_data;
         hold_valid <= 1'b1;
      end else if (clear) begin
         hold_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/par_serial_tx.sv
// rtl/par_serial_tx.sv - serialises parallel words one bit per clock with a one-word holding buffer
module par_serial_tx
   import par_serial_pkg::*;
#(
   parameter int WORD_SIZE = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] data_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic                 serial_out,
   output logic                 serial_valid,
   output logic                 frame_start,
   output logic [CNT_W-1:0]     word_count
);

   localparam int             BCW      = clog2(WORD_SIZE);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_SIZE - 1);

   state_t                 state, state_nxt;
   logic [WORD_SIZE-1:0]   shifter, shifter_nxt, shifted;
   logic [BCW-1:0]         bit_cnt, bit_cnt_nxt;
   logic [CNT_W-1:0]       word_cnt;
   logic [WORD_SIZE-1:0]   hold_data;
   logic                   hold_valid;
   logic                   hold_load, hold_clear;
   logic                   count_inc;
   logic                   accept;
   logic                   last_bit;

   // Ready depends only on registered hold occupancy and reset, never on valid_in
   assign ready_out    = !hold_valid && !reset;
   assign accept       = valid_in && ready_out;
   assign last_bit     = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
   assign serial_valid = (state == S_SHIFT);
   assign serial_out   = serial_valid & (MSB_FIRST ? shifter[WORD_SIZE-1] : shifter[0]);
   assign frame_start  = serial_valid && (bit_cnt == '0);
   assign word_count   = word_cnt;

   par_serial_hold #(
      .WORD_SIZE (WORD_SIZE)
   ) u_hold (
      .clk        (clk),
      .reset      (reset),
      .load       (hold_load),
      .clear      (hold_clear),
      .load_data  (data_in),
      .hold_data  (hold_data),
      .hold_valid (hold_valid)
   );

   // Shifter advanced one position toward the output end
   always_comb begin
      shifted = shifter;
      if (MSB_FIRST) begin
         shifted = {shifter[WORD_SIZE-2:0], 1'b0};
      end else begin
         shifted = {1'b0, shifter[WORD_SIZE-1:1]};
      end
   end

   // Next-state logic: start, shift, and end-of-word hand-off (hold, then bypass, then idle)
   always_comb begin
      state_nxt   = state;
      shifter_nxt = shifter;
      bit_cnt_nxt = bit_cnt;
      hold_load   = 1'b0;
      hold_clear  = 1'b0;
      count_inc   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               shifter_nxt = data_in;
               bit_cnt_nxt = '0;
               state_nxt   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (last_bit) begin
               count_inc   = 1'b1;
               bit_cnt_nxt = '0;
               if (hold_valid) begin
                  shifter_nxt = hold_data;
                  hold_clear  = 1'b1;
               end else if (accept) begin
                  shifter_nxt = data_in;
               end else begin
                  shifter_nxt = '0;
                  state_nxt   = S_IDLE;
               end
            end else begin
               shifter_nxt = shifted;
               bit_cnt_nxt = bit_cnt + BCW'(1);
               hold_load   = accept;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, shifter and counters; reset discards any partial word
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         shifter  <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
      end else begin
         state   <= state_nxt;
         shifter <= shifter_nxt;
         bit_cnt <= bit_cnt_nxt;
         if (count_inc) begin
            word_cnt <= word_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_par_serial_tx.sv
// tb/tb_par_serial_tx.sv - randomized self-checking bench for par_serial_tx against a queue model
module tb_par_serial_tx;

   localparam int W  = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          valid_in = 1'b0;
   logic [W-1:0]  data_in = '0;

   logic          ready_m, so_m, sv_m, fs_m;
   logic [CW-1:0] wc_m;
   logic          ready_l, so_l, sv_l, fs_l;
   logic [CW-1:0] wc_l;

   int checks = 0;
   int errors = 0;

   // model: word being sent, bits remaining, waiting words, finished-word count
   logic [W-1:0]  m_cur;
   int            m_left;
   logic [W-1:0]  m_q[$];
   logic [CW-1:0] m_cnt;
   int            n_acc;

   always #5 clk = ~clk;

   par_serial_tx #(.WORD_SIZE(W), .MSB_FIRST(1'b1), .CNT_W(CW)) dut_msb (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .ready_out    (ready_m),
      .serial_out   (so_m),
      .serial_valid (sv_m),
      .frame_start  (fs_m),
      .word_count   (wc_m)
   );

   par_serial_tx #(.WORD_SIZE(W), .MSB_FIRST(1'b0), .CNT_W(CW)) dut_lsb (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .ready_out    (ready_l),
      .serial_out   (so_l),
      .serial_valid (sv_l),
      .frame_start  (fs_l),
      .word_count   (wc_l)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, compare outputs with the model, then advance the model past the edge
   task automatic step(input logic r, input logic v, input logic [W-1:0] d);
      logic m_ready;
      int   idx;
      int   eb_m;
      int   eb_l;
      @(negedge clk);
      reset    = r;
      valid_in = v;
      data_in  = d;
      #1;
      m_ready = !r && (m_q.size() == 0);
      eb_m = 0;
      eb_l = 0;
      if (m_left > 0) begin
         idx  = W - m_left;
         eb_m = (int'(m_cur) >> (W - 1 - idx)) & 1;
         eb_l = (int'(m_cur) >> idx) & 1;
      end
      check("ready_msb", 32'(ready_m), 32'(m_ready));
      check("ready_lsb", 32'(ready_l), 32'(m_ready));
      check("valid_msb", 32'(sv_m), 32'(m_left > 0));
      check("valid_lsb", 32'(sv_l), 32'(m_left > 0));
      check("bit_msb", 32'(so_m), 32'(eb_m));
      check("bit_lsb", 32'(so_l), 32'(eb_l));
      check("fstart_msb", 32'(fs_m), 32'(m_left == W));
      check("fstart_lsb", 32'(fs_l), 32'(m_left == W));
      check("count_msb", 32'(wc_m), 32'(m_cnt));
      check("count_lsb", 32'(wc_l), 32'(m_cnt));
      if (r) begin
         m_q.delete();
         m_left = 0;
         m_cnt  = '0;
         m_cur  = '0;
      end else begin
         if (v && m_ready) begin
            m_q.push_back(d);
            n_acc++;
         end
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_cnt = m_cnt + CW'(1);
            end
         end
         if (m_left == 0 && m_q.size() > 0) begin
            m_cur  = m_q.pop_front();
            m_left = W;
         end
      end
   endtask

   initial begin
      logic [W-1:0] seq_m;
      logic [W-1:0] seq_l;
      int           guard;
      m_cur  = '0;
      m_left = 0;
      m_cnt  = '0;
      n_acc  = 0;

      // reset held with valid_in high: nothing may be accepted
      repeat (3) step(1'b1, 1'b1, 4'hA);
      step(1'b0, 1'b0, 4'h0);
      check("reset_count", 32'(wc_m), 32'd0);
      check("reset_ready_after", 32'(ready_m), 32'd1);

      // single word 1011: MSB-first 1,0,1,1 and LSB-first 1,1,0,1
      seq_m = 4'b1011;
      seq_l = 4'b1101;
      step(1'b0, 1'b1, 4'b1011);
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b0, 4'h0);
         check("single_bit_msb", 32'(so_m), 32'(seq_m[W-1-i]));
         check("single_bit_lsb", 32'(so_l), 32'(seq_l[W-1-i]));
         check("single_fstart", 32'(fs_m), 32'(i == 0));
      end
      step(1'b0, 1'b0, 4'h0);
      check("single_done_valid", 32'(sv_m), 32'd0);
      check("single_done_count", 32'(wc_m), 32'd1);

      // reset mid-frame: 1100 sending, 0101 held, reset after two bits
      step(1'b0, 1'b1, 4'b1100);
      step(1'b0, 1'b1, 4'b0101);
      step(1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      check("abort_valid", 32'(sv_m), 32'd0);
      repeat (8) begin
         step(1'b0, 1'b0, 4'h0);
         check("abort_silent", 32'(sv_m | sv_l), 32'd0);
      end
      check("abort_count", 32'(wc_m), 32'd0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), W'($urandom));
      end

      // counter wrap: exactly 256 words after a reset
      step(1'b1, 1'b0, 4'h0);
      n_acc = 0;
      guard = 0;
      while (n_acc < 256 && guard < 3000) begin
         step(1'b0, 1'b1, W'($urandom));
         guard++;
      end
      check("wrap_accept_budget", 32'(n_acc), 32'd256);
      repeat (2 * W) step(1'b0, 1'b0, 4'h0);
      check("wrap_count_msb", 32'(wc_m), 32'd0);
      check("wrap_count_lsb", 32'(wc_l), 32'd0);
      check("wrap_idle", 32'(sv_m), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
